// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-requester round-robin arbiter with 4:1 data select.
//   state_t  : arbiter state (IDLE = no owner, BUSY = one owner)
//   NUM_REQ  : number of requesters
//   SEL_W    : width of the binary owner index
//   rr_pick  : combinational round-robin scan of a request vector
package mux4_rr_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // First set bit of req, scanning upward from (last+1) and wrapping so
    // that last itself is considered at the very end. Walking the offsets
    // from far to near lets the nearest hit overwrite the earlier ones.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [SEL_W-1:0]   last);
        pick_t            p;
        logic [SEL_W-1:0] cand;
        p.found = 1'b0;
        p.idx   = last;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = last + SEL_W'(i);
            if (req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux_4x1.sv
// Plain 4:1 single-bit data selector.
//   i_d   : four data bits, i_d[k] belongs to requester k
//   i_sel : binary index of the selected bit
//   o_y   : i_d[i_sel]
module mux_4x1
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_d,
    input  logic [SEL_W-1:0]   i_sel,
    output logic               o_y
);

    assign o_y = i_d[i_sel];

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four requesters that owns a shared 4:1 data select.
// A grant is held while its requester keeps req high, for at most MAX_HOLD
// consecutive cycles; hand-over to the next requester happens at the release
// edge with no idle cycle in between.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   req   : per-requester request
//   d     : per-requester data bit
//   gnt   : registered one-hot grant (zero when idle)
//   sel   : registered binary index of the current owner (held while idle)
//   valid : registered, high while a grant is active
//   o     : d[sel] while valid, otherwise 0
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [NUM_REQ-1:0]  d,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [SEL_W-1:0]    sel,
    output logic                valid,
    output logic                o
);

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [SEL_W-1:0]     r_sel;
    logic                 r_valid;
    logic [7:0]           r_cnt;
    logic [SEL_W-1:0]     r_last;

    state_t               w_state_nxt;
    logic [NUM_REQ-1:0]   w_gnt_nxt;
    logic [SEL_W-1:0]     w_sel_nxt;
    logic                 w_valid_nxt;
    logic [7:0]           w_cnt_nxt;
    logic [SEL_W-1:0]     w_last_nxt;

    logic [NUM_REQ-1:0]   w_other;
    pick_t                w_pick_all;
    pick_t                w_pick_other;
    logic                 w_release;
    logic                 w_new_grant;
    logic [SEL_W-1:0]     w_new_idx;
    logic                 w_mux_o;

    // Requests from everyone except the current owner; gnt is one-hot on the
    // owner, so masking with it removes exactly that requester.
    assign w_other      = req & ~r_gnt;
    assign w_pick_all   = rr_pick(req, r_last);
    assign w_pick_other = rr_pick(w_other, r_last);
    assign w_release    = !req[r_sel] || (r_cnt == HOLD_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_valid_nxt = r_valid;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_new_grant = 1'b0;
        w_new_idx   = r_last;

        case (r_state)
            IDLE: begin
                if (w_pick_all.found) begin
                    w_new_grant = 1'b1;
                    w_new_idx   = w_pick_all.idx;
                end
            end
            BUSY: begin
                if (!w_release) begin
                    if (r_cnt != HOLD_MAX) begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end else if (w_pick_other.found) begin
                    w_new_grant = 1'b1;
                    w_new_idx   = w_pick_other.idx;
                end else if (req[r_sel]) begin
                    // Hold expired but nobody else is waiting: keep the
                    // grant and start a fresh hold window.
                    w_cnt_nxt = 8'd1;
                end else begin
                    // sel deliberately keeps its last value while idle.
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_valid_nxt = 1'b0;
                    w_cnt_nxt   = 8'd0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_valid_nxt = 1'b0;
                w_cnt_nxt   = 8'd0;
            end
        endcase

        if (w_new_grant) begin
            w_state_nxt          = BUSY;
            w_gnt_nxt            = '0;
            w_gnt_nxt[w_new_idx] = 1'b1;
            w_sel_nxt            = w_new_idx;
            w_valid_nxt          = 1'b1;
            w_cnt_nxt            = 8'd1;
            w_last_nxt           = w_new_idx;
        end
    end

    // last resets to the top index so that requester 0 wins the first scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_cnt   <= 8'd0;
            r_last  <= SEL_W'(NUM_REQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_valid <= w_valid_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    mux_4x1 u_mux (
        .i_d   (d),
        .i_sel (r_sel),
        .o_y   (w_mux_o)
    );

    assign gnt   = r_gnt;
    assign sel   = r_sel;
    assign valid = r_valid;
    assign o     = r_valid & w_mux_o;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: two instances (MAX_HOLD=2 and MAX_HOLD=3) share
// the same stimulus; a behavioural model pushes the expected outputs of each
// into a queue as stimulus is applied, and each scenario task pops them after
// the clock edge and compares, together with scenario-specific constants.
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt2, gnt3;
    logic [1:0] sel2, sel3;
    logic       valid2, valid3, o2, o3;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.MAX_HOLD(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .d(d),
        .gnt(gnt2), .sel(sel2), .valid(valid2), .o(o2)
    );

    mux4_rr_arbiter #(.MAX_HOLD(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req(req), .d(d),
        .gnt(gnt3), .sel(sel3), .valid(valid3), .o(o3)
    );

    typedef struct {
        bit       valid;
        bit [1:0] sel;
        int       cnt;
        bit [1:0] last;
    } mstate_t;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic       o;
    } exp_t;

    exp_t    q2[$];
    exp_t    q3[$];
    exp_t    e2, e3;
    mstate_t m2, m3;
    int      total = 0;
    int      bad   = 0;

    function automatic mstate_t model_reset();
        mstate_t s;
        s.valid = 1'b0;
        s.sel   = 2'd0;
        s.cnt   = 0;
        s.last  = 2'd3;
        return s;
    endfunction

    // One clock edge of the arbiter as described by the requirements.
    function automatic mstate_t model_step(mstate_t s, logic [3:0] r, int mh);
        mstate_t    n;
        logic [3:0] cand;
        bit         rel;
        int         idx;
        n = s;
        if (!s.valid) rel = 1'b1;
        else          rel = (r[s.sel] == 1'b0) || (s.cnt == mh);
        cand = r;
        if (s.valid) begin
            cand[s.sel] = 1'b0;
            if (cand == 4'b0) cand = r;
        end
        if (!rel) begin
            n.cnt = s.cnt + 1;
        end else if (cand == 4'b0) begin
            n.valid = 1'b0;
            n.cnt   = 0;
        end else begin
            idx = -1;
            for (int i = 1; i <= 4; i++) begin
                if (idx < 0 && cand[(int'(s.last) + i) % 4]) idx = (int'(s.last) + i) % 4;
            end
            n.valid = 1'b1;
            n.sel   = 2'(idx);
            n.last  = 2'(idx);
            n.cnt   = 1;
        end
        return n;
    endfunction

    function automatic exp_t to_exp(mstate_t s, logic [3:0] dd);
        exp_t e;
        e.gnt = 4'b0;
        if (s.valid) e.gnt[s.sel] = 1'b1;
        e.sel   = s.sel;
        e.valid = s.valid;
        e.o     = s.valid ? dd[s.sel] : 1'b0;
        return e;
    endfunction

    // Apply one cycle of stimulus at the falling edge, record what both
    // instances must show after the next rising edge, then move to 1 ns
    // past that rising edge.
    task automatic drive(input logic [3:0] r, input logic [3:0] dd);
        @(negedge clk);
        req = r;
        d   = dd;
        m2  = model_step(m2, r, 2);
        m3  = model_step(m3, r, 3);
        q2.push_back(to_exp(m2, dd));
        q3.push_back(to_exp(m3, dd));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0;
        d     = 4'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m2    = model_reset();
        m3    = model_reset();
        q2.delete();
        q3.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0;
        d     = 4'b0;
        m2    = model_reset();
        m3    = model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({gnt2, sel2, valid2, o2} !== 8'b0) begin
            bad++;
            $display("FAIL reset_dut2 got gnt=%b sel=%0d valid=%b o=%b want all zero", gnt2, sel2, valid2, o2);
        end
        total++;
        if ({gnt3, sel3, valid3, o3} !== 8'b0) begin
            bad++;
            $display("FAIL reset_dut3 got gnt=%b sel=%0d valid=%b o=%b want all zero", gnt3, sel3, valid3, o3);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        drive(4'b0001, 4'b0001);
        e2 = q2.pop_front();
        e3 = q3.pop_front();
        total++;
        if ({gnt2, sel2, valid2, o2} !== {e2.gnt, e2.sel, e2.valid, e2.o}) begin
            bad++;
            $display("FAIL single_grant_sb2 got=%b want=%b", {gnt2, sel2, valid2, o2}, {e2.gnt, e2.sel, e2.valid, e2.o});
        end
        total++;
        if ({gnt3, sel3, valid3, o3} !== {e3.gnt, e3.sel, e3.valid, e3.o}) begin
            bad++;
            $display("FAIL single_grant_sb3 got=%b want=%b", {gnt3, sel3, valid3, o3}, {e3.gnt, e3.sel, e3.valid, e3.o});
        end
        total++;
        if ({gnt2, sel2, valid2, o2} !== {4'b0001, 2'd0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL single_grant got gnt=%b sel=%0d valid=%b o=%b want 0001/0/1/1", gnt2, sel2, valid2, o2);
        end
        drive(4'b0000, 4'b0001);
        e2 = q2.pop_front();
        e3 = q3.pop_front();
        total++;
        if ({gnt2, sel2, valid2, o2} !== {e2.gnt, e2.sel, e2.valid, e2.o}) begin
            bad++;
            $display("FAIL single_drop_sb2 got=%b want=%b", {gnt2, sel2, valid2, o2}, {e2.gnt, e2.sel, e2.valid, e2.o});
        end
        total++;
        if ({gnt3, sel3, valid3, o3} !== {e3.gnt, e3.sel, e3.valid, e3.o}) begin
            bad++;
            $display("FAIL single_drop_sb3 got=%b want=%b", {gnt3, sel3, valid3, o3}, {e3.gnt, e3.sel, e3.valid, e3.o});
        end
        total++;
        if ({gnt2, sel2, valid2, o2} !== {4'b0000, 2'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL single_drop got gnt=%b sel=%0d valid=%b o=%b want 0000/0/0/0", gnt2, sel2, valid2, o2);
        end
    endtask

    task automatic test_rotation();
        int         own[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        logic [3:0] want;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive(4'b1111, 4'($urandom));
            e2 = q2.pop_front();
            e3 = q3.pop_front();
            total++;
            if ({gnt2, sel2, valid2, o2} !== {e2.gnt, e2.sel, e2.valid, e2.o}) begin
                bad++;
                $display("FAIL rotation_sb2 cycle=%0d got=%b want=%b", c, {gnt2, sel2, valid2, o2}, {e2.gnt, e2.sel, e2.valid, e2.o});
            end
            total++;
            if ({gnt3, sel3, valid3, o3} !== {e3.gnt, e3.sel, e3.valid, e3.o}) begin
                bad++;
                $display("FAIL rotation_sb3 cycle=%0d got=%b want=%b", c, {gnt3, sel3, valid3, o3}, {e3.gnt, e3.sel, e3.valid, e3.o});
            end
            want = 4'b0;
            want[own[c]] = 1'b1;
            total++;
            if ({gnt2, valid2} !== {want, 1'b1}) begin
                bad++;
                $display("FAIL rotation_owner cycle=%0d got gnt=%b valid=%b want gnt=%b valid=1", c, gnt2, valid2, want);
            end
        end
    endtask

    task automatic test_expiry();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(4'b0100, 4'($urandom));
            e2 = q2.pop_front();
            e3 = q3.pop_front();
            total++;
            if ({gnt3, sel3, valid3, o3} !== {e3.gnt, e3.sel, e3.valid, e3.o}) begin
                bad++;
                $display("FAIL expiry_sb3 cycle=%0d got=%b want=%b", c, {gnt3, sel3, valid3, o3}, {e3.gnt, e3.sel, e3.valid, e3.o});
            end
            total++;
            if ({gnt3, sel3, valid3} !== {4'b0100, 2'd2, 1'b1}) begin
                bad++;
                $display("FAIL expiry_hold cycle=%0d got gnt=%b sel=%0d valid=%b want 0100/2/1", c, gnt3, sel3, valid3);
            end
        end
        // Owner 2 drops; with last still 2 the scan starts at 3.
        drive(4'b1011, 4'($urandom));
        e2 = q2.pop_front();
        e3 = q3.pop_front();
        total++;
        if ({gnt2, sel2, valid2, o2} !== {e2.gnt, e2.sel, e2.valid, e2.o}) begin
            bad++;
            $display("FAIL expiry_next_sb2 got=%b want=%b", {gnt2, sel2, valid2, o2}, {e2.gnt, e2.sel, e2.valid, e2.o});
        end
        total++;
        if ({gnt3, sel3} !== {4'b1000, 2'd3}) begin
            bad++;
            $display("FAIL expiry_next got gnt=%b sel=%0d want 1000/3", gnt3, sel3);
        end
    endtask

    task automatic test_handover();
        do_reset();
        drive(4'b0010, 4'b0010);
        e2 = q2.pop_front();
        e3 = q3.pop_front();
        total++;
        if ({gnt2, sel2, valid2, o2} !== {4'b0010, 2'd1, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL handover_first got gnt=%b sel=%0d valid=%b o=%b want 0010/1/1/1", gnt2, sel2, valid2, o2);
        end
        drive(4'b1001, 4'b0001);
        e2 = q2.pop_front();
        e3 = q3.pop_front();
        total++;
        if ({gnt2, sel2, valid2, o2} !== {e2.gnt, e2.sel, e2.valid, e2.o}) begin
            bad++;
            $display("FAIL handover_sb2 got=%b want=%b", {gnt2, sel2, valid2, o2}, {e2.gnt, e2.sel, e2.valid, e2.o});
        end
        total++;
        if ({gnt3, sel3, valid3, o3} !== {4'b1000, 2'd3, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL handover_next got gnt=%b sel=%0d valid=%b o=%b want 1000/3/1/0", gnt3, sel3, valid3, o3);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(4'b1111, 4'b1111);
        e2 = q2.pop_front();
        e3 = q3.pop_front();
        total++;
        if ({gnt2, valid2, o2} !== {4'b0001, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL async_pre got gnt=%b valid=%b o=%b want 0001/1/1", gnt2, valid2, o2);
        end
        // Between edges: reset must take effect with no clock edge.
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({gnt2, valid2, o2} !== {4'b0000, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL async_drop_dut2 got gnt=%b valid=%b o=%b want 0000/0/0", gnt2, valid2, o2);
        end
        total++;
        if ({gnt3, valid3, o3} !== {4'b0000, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL async_drop_dut3 got gnt=%b valid=%b o=%b want 0000/0/0", gnt3, valid3, o3);
        end
        m2 = model_reset();
        m3 = model_reset();
        q2.delete();
        q3.delete();
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0;
        drive(4'b1111, 4'b1110);
        e2 = q2.pop_front();
        e3 = q3.pop_front();
        total++;
        if ({gnt2, sel2, valid2, o2} !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL async_first_owner got gnt=%b sel=%0d valid=%b o=%b want 0001/0/1/0", gnt2, sel2, valid2, o2);
        end
        total++;
        if ({gnt3, sel3, valid3, o3} !== {e3.gnt, e3.sel, e3.valid, e3.o}) begin
            bad++;
            $display("FAIL async_first_sb3 got=%b want=%b", {gnt3, sel3, valid3, o3}, {e3.gnt, e3.sel, e3.valid, e3.o});
        end
    endtask

    task automatic test_random();
        logic [3:0] cur;
        logic [3:0] flip;
        int         w2[4];
        int         w3[4];
        do_reset();
        cur = 4'b0;
        for (int k = 0; k < 4; k++) begin
            w2[k] = 0;
            w3[k] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            flip = 4'b0;
            for (int k = 0; k < 4; k++) flip[k] = ($urandom_range(0, 3) == 0);
            cur = cur ^ flip;
            drive(cur, 4'($urandom));
            e2 = q2.pop_front();
            e3 = q3.pop_front();
            total++;
            if ({gnt2, sel2, valid2, o2} !== {e2.gnt, e2.sel, e2.valid, e2.o}) begin
                bad++;
                if (bad < 20) $display("FAIL random_sb2 cycle=%0d req=%b got=%b want=%b", c, cur, {gnt2, sel2, valid2, o2}, {e2.gnt, e2.sel, e2.valid, e2.o});
            end
            total++;
            if ({gnt3, sel3, valid3, o3} !== {e3.gnt, e3.sel, e3.valid, e3.o}) begin
                bad++;
                if (bad < 20) $display("FAIL random_sb3 cycle=%0d req=%b got=%b want=%b", c, cur, {gnt3, sel3, valid3, o3}, {e3.gnt, e3.sel, e3.valid, e3.o});
            end
            total++;
            if (!$onehot0(gnt2) || (gnt2[sel2] !== valid2) || (o2 !== (valid2 ? d[sel2] : 1'b0))) begin
                bad++;
                if (bad < 20) $display("FAIL random_invariant_dut2 cycle=%0d gnt=%b sel=%0d valid=%b o=%b d=%b", c, gnt2, sel2, valid2, o2, d);
            end
            total++;
            if (!$onehot0(gnt3) || (gnt3[sel3] !== valid3) || (o3 !== (valid3 ? d[sel3] : 1'b0))) begin
                bad++;
                if (bad < 20) $display("FAIL random_invariant_dut3 cycle=%0d gnt=%b sel=%0d valid=%b o=%b d=%b", c, gnt3, sel3, valid3, o3, d);
            end
            for (int k = 0; k < 4; k++) begin
                if (cur[k] && !gnt2[k]) w2[k]++;
                else                    w2[k] = 0;
                if (cur[k] && !gnt3[k]) w3[k]++;
                else                    w3[k] = 0;
                total++;
                if (w2[k] > 3 * 2 || w3[k] > 3 * 3) begin
                    bad++;
                    if (bad < 20) $display("FAIL random_starve cycle=%0d req=%0d wait2=%0d wait3=%0d want <=6 and <=9", c, k, w2[k], w3[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_expiry();
        test_handover();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, is the maximum number of consecutive cycles one grant is held; legal range 1..255.
REQ-002 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1, is the asynchronous active-low reset.
REQ-004 Port req, input, 4, is the per-requester request; bit k belongs to requester k.
REQ-005 Port d, input, 4, is the per-requester data bit; d[k] belongs to requester k.
REQ-006 Port gnt, output, 4, is the one-hot grant, registered.
REQ-007 Port sel, output, 2, is the binary index of the current owner, registered; it drives the 4:1 select.
REQ-008 Port valid, output, 1, is high while any grant is active, registered.
REQ-009 Port o, output, 1, is the shared output; it equals d[sel] when valid=1 and 0 otherwise (combinational from sel, valid and d).

Function
REQ-010 Two states SHALL exist: IDLE (no owner) and BUSY (one owner).
REQ-011 In IDLE with req==0, the block SHALL stay in IDLE with gnt=0 and valid=0.
REQ-012 In IDLE with req!=0, the block SHALL enter BUSY at the next edge. The owner is the first set req bit, scanning upward from (last+1) mod 4 and wrapping. Latency is one cycle from req to gnt.
REQ-013 last SHALL be a 2-bit register holding the index of the most recent owner; it updates on every new grant.
REQ-014 In BUSY, a hold counter SHALL count granted cycles: 1 in the first granted cycle, +1 per cycle, saturating at MAX_HOLD.
REQ-015 Release SHALL occur when req[sel]==0, or when the hold counter equals MAX_HOLD.
REQ-016 On release with any other req bit set, the next owner SHALL be granted at the same edge (no bubble) by the REQ-012 scan. The counter restarts at 1.
REQ-017 On release with no other req bit set but req[sel] still high (hold expiry), the same owner SHALL be re-granted with the counter restarted at 1. gnt stays asserted.
REQ-018 On release with req==0, the block SHALL return to IDLE: gnt=0, valid=0, and sel holds its previous value.
REQ-019 Simultaneous requests SHALL be ordered strictly round-robin; no requester waits more than 3*MAX_HOLD cycles while its req stays high.
REQ-020 gnt SHALL always be one-hot or zero, and gnt[sel]==valid in every cycle.
REQ-021 A requester that deasserts req while not granted SHALL lose its place with no side effect.

Reset
REQ-022 While rst_n==0, the block SHALL be asynchronously forced to: state IDLE, gnt=0, sel=0, valid=0, counter=0, last=3 (requester 0 has highest priority after reset).
REQ-023 Reset asserted mid-grant SHALL drop gnt and valid immediately, without waiting for a clock edge; o SHALL then read 0.
REQ-024 After rst_n rises, the first arbitration SHALL occur at the first rising edge with req!=0.

Structure
REQ-025 A shared package SHALL hold the state enumeration (IDLE, BUSY), the requester count constant (4) and the select width constant (2).
REQ-026 The 4:1 data select SHALL be a single sub-module instance, mux_4x1, driven by d and sel; o is its output gated by valid.
REQ-027 Round-robin next-owner selection SHALL be a pure function of req and last, with no additional state.

Verification
REQ-028 Reset, then req=0001, d=0001: next edge gnt=0001, sel=0, valid=1, o=1; drop req: next edge gnt=0000, valid=0, o=0.
REQ-029 req=1111 held, MAX_HOLD=2: grants rotate 0,1,2,3,0, each held 2 cycles with no idle cycle between owners.
REQ-030 Only req[2] held, MAX_HOLD=3: gnt=0100 stays continuous across expiry with the counter restarting; last stays 2.
REQ-031 Owner 1 granted, req=0010 drops while req=1001 is raised at the same edge: next owner is 3 (scan 2,3), not 0.
REQ-032 rst_n pulsed low mid-grant, between edges: gnt, valid and o go to 0 immediately; after release with req=1111, first owner is 0.
REQ-033 Random req/d stimulus over 10k cycles: a checker confirms one-hot gnt, o==(valid ? d[sel] : 0), and starvation bound 3*MAX_HOLD.
